// File: rtl/delay_line_ctrl_pkg.sv
// delay_pkg: shared state encoding and defaults for the delay-line sequencer
package delay_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FREEZE = 2'd3} delay_state_t;
  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int MIN_OFFSET = 1;
endpackage

// File: rtl/delay_line_ctrl_offset_slew.sv
// offset_slew: clamps the requested delay to what has been written and steps toward it by 1
module offset_slew
#(
  parameter int W = delay_pkg::DEFAULT_ADDR_WIDTH,
  parameter int MIN_OFFSET = delay_pkg::MIN_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] target,
  input  logic [W-1:0] fill_cnt,
  output logic [W-1:0] cur_offset,
  output logic [W-1:0] nxt_offset
);
  import delay_pkg::*;
  localparam logic [W-1:0] MIN = W'(MIN_OFFSET);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W:0] ONE1 = (W+1)'(1);
  logic [W:0] room;
  logic [W-1:0] hi, lim;
  // room counts the sample being written on this tick
  always_comb begin
    room = {1'b0, fill_cnt} + ONE1;
    hi = ({1'b0, target} > room) ? room[W-1:0] : target;
    lim = (hi < MIN) ? MIN : hi;
    nxt_offset = !en ? cur_offset :
                 (cur_offset < lim) ? cur_offset + ONE :
                 (cur_offset > lim) ? cur_offset - ONE : cur_offset;
  end
  always_ff @(posedge clk)
    cur_offset <= rst ? MIN : nxt_offset;
endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: tick-driven sequencer for a dual-port RAM audio delay line
module delay_line_ctrl
#(
  parameter int ADDR_WIDTH = delay_pkg::DEFAULT_ADDR_WIDTH,
  parameter int MIN_OFFSET = delay_pkg::MIN_OFFSET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  input  logic [ADDR_WIDTH-1:0] offset_target,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH-1:0] cur_offset,
  output logic [1:0]            state
);
  import delay_pkg::*;
  localparam int W = ADDR_WIDTH;
  localparam logic [W-1:0] MIN = W'(MIN_OFFSET);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W:0] ONE1 = (W+1)'(1);
  delay_state_t st, st_nxt;
  logic [W-1:0] wr_ptr, loop_ptr, fill_cnt, nxt_offset, rp, tgt;
  logic live, act_fill, act_run, act_frz, filled;
  assign live = tick && !stop && (st == RUN || st == FREEZE);
  assign act_fill = tick && !stop && st == FILL;
  assign act_run = live && !freeze;
  assign act_frz = live && freeze;
  assign tgt = (offset_target < MIN) ? MIN : offset_target;
  // fill ends once the buffer holds the requested delay, counting this tick's write
  assign filled = ({1'b0, fill_cnt} + ONE1) >= {1'b0, tgt};
  assign rp = (st == FREEZE) ? loop_ptr : wr_ptr - cur_offset;
  assign state = st;
  offset_slew #(.W(W), .MIN_OFFSET(MIN_OFFSET)) u_slew (
    .clk(clk),
    .rst(rst),
    .en(act_fill || act_run),
    .target(offset_target),
    .fill_cnt(fill_cnt),
    .cur_offset(cur_offset),
    .nxt_offset(nxt_offset)
  );
  always_ff @(posedge clk)
    st <= rst ? IDLE : st_nxt;
  always_comb begin
    st_nxt = stop ? IDLE :
             (st == IDLE) ? (start ? FILL : IDLE) :
             (act_fill && filled) ? RUN :
             live ? (freeze ? FREEZE : RUN) : st;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      loop_ptr <= '0;
      fill_cnt <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      dout_valid <= 1'b0;
    end else begin
      wr_en <= act_fill || act_run;
      rd_en <= act_run || act_frz;
      dout_valid <= rd_en;
      if (act_fill || act_run) begin
        wr_addr <= wr_ptr;
        wr_ptr <= wr_ptr + ONE;
        fill_cnt <= (fill_cnt == '1) ? fill_cnt : fill_cnt + ONE;
      end
      if (act_run) rd_addr <= wr_ptr - nxt_offset;
      // replay window is the last cur_offset samples before the write pointer
      if (act_frz) begin
        rd_addr <= rp;
        loop_ptr <= (rp == wr_ptr - ONE) ? wr_ptr - cur_offset : rp + ONE;
      end
      if (st == IDLE && !stop && start) begin
        wr_ptr <= '0;
        fill_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: scoreboard bench; stimulus queues expected pulses, a monitor checks them
module tb_delay_line_ctrl;
  localparam int D = 512;
  localparam int MINO = 1;
  typedef struct {int cyc; bit we; int wa; bit re; int ra; int off; int st;} txn_t;
  logic clk = 0, rst = 1, tick = 0, start = 0, stop = 0, freeze = 0;
  logic [8:0] target = 9'd1;
  logic wr_en, rd_en, dout_valid;
  logic [8:0] wr_addr, rd_addr, cur_offset;
  logic [1:0] state;
  int checks = 0, errors = 0, cyc = 0;
  bit rst_q = 1, mon_on = 0, pend_dv = 0, wrap_seen = 0;
  int obs_wa = -1, obs_ra = -1, obs_off = -1, prev_wa = -1, ra_at1 = -1, wr_cnt = 0;
  int m_st, m_wr, m_loop, m_fill, m_off;
  txn_t q[$];
  int frz_exp[7] = '{17, 18, 19, 17, 18, 19, 17};

  delay_line_ctrl #(.ADDR_WIDTH(9), .MIN_OFFSET(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .freeze(freeze),
    .offset_target(target), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en),
    .rd_addr(rd_addr), .dout_valid(dout_valid), .cur_offset(cur_offset), .state(state)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_q = rst;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 100000", cyc);
    $fatal(1);
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int wrapd(input int x);
    return ((x % D) + D) % D;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_st = 0; m_wr = 0; m_loop = 0; m_fill = 0; m_off = MINO;
  endtask

  task automatic model_slew();
    int t, lim;
    t = (int'(target) < MINO) ? MINO : int'(target);
    lim = (t < m_fill + 1) ? t : m_fill + 1;
    if (lim < MINO) lim = MINO;
    if (m_off < lim) m_off++;
    else if (m_off > lim) m_off--;
  endtask

  task automatic do_tick(input int gap);
    txn_t e;
    int t, rp;
    bit go;
    e.cyc = cyc + 1; e.we = 0; e.wa = 0; e.re = 0; e.ra = 0;
    t = (int'(target) < MINO) ? MINO : int'(target);
    if (m_st == 1) begin
      go = (m_fill + 1 >= t);
      model_slew();
      e.we = 1; e.wa = m_wr;
      m_wr = wrapd(m_wr + 1);
      if (m_fill < D - 1) m_fill++;
      if (go) m_st = 2;
    end else if (m_st >= 2 && !freeze) begin
      model_slew();
      e.we = 1; e.wa = m_wr; e.re = 1; e.ra = wrapd(m_wr - m_off);
      m_wr = wrapd(m_wr + 1);
      if (m_fill < D - 1) m_fill++;
      m_st = 2;
    end else if (m_st >= 2) begin
      rp = (m_st == 3) ? m_loop : wrapd(m_wr - m_off);
      e.re = 1; e.ra = rp;
      m_loop = (rp == wrapd(m_wr - 1)) ? wrapd(m_wr - m_off) : wrapd(rp + 1);
      m_st = 3;
    end
    e.off = m_off; e.st = m_st;
    if (e.we || e.re) q.push_back(e);
    tick = 1; step(); tick = 0;
    repeat (gap - 1) step();
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
    model_reset();
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
    if (m_st == 0) begin m_st = 1; m_wr = 0; m_fill = 0; end
  endtask

  task automatic do_stop();
    stop = 1; step(); stop = 0;
    m_st = 0;
  endtask

  initial forever begin
    txn_t e;
    @(negedge clk);
    if (mon_on) begin
      chk("dout_valid", dout_valid, int'(pend_dv && !rst_q));
      pend_dv = 0;
      if (wr_en || rd_en) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got wr_en=%0d rd_en=%0d expected none (cycle %0d)", wr_en, rd_en, cyc);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("wr_en", wr_en, e.we);
          chk("rd_en", rd_en, e.re);
          if (e.we) chk("wr_addr", wr_addr, e.wa);
          if (e.re) chk("rd_addr", rd_addr, e.ra);
          chk("cur_offset", cur_offset, e.off);
          chk("state", state, e.st);
          pend_dv = e.re;
        end
        obs_off = cur_offset;
        if (rd_en) obs_ra = rd_addr;
        if (wr_en) begin
          if (prev_wa == 511 && wr_addr == 0) wrap_seen = 1;
          if (rd_en && wr_addr == 1) ra_at1 = rd_addr;
          prev_wa = wr_addr;
          obs_wa = wr_addr;
          wr_cnt++;
        end
      end
    end
  end

  initial begin
    int prev, c0;
    // reset then idle ticks
    do_reset();
    mon_on = 1;
    chk("rst_state", state, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_cur_offset", cur_offset, 1);
    repeat (10) do_tick(2);
    chk("idle_state", state, 0);
    // fill and run at offset 4
    target = 9'd4;
    do_start();
    chk("fill_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      do_tick(3);
      chk("fill_wa", obs_wa, i);
      chk("fill_off", obs_off, i + 1);
    end
    chk("run_state", state, 2);
    do_tick(3);
    chk("run_wa", obs_wa, 4);
    chk("run_ra", obs_ra, 0);
    // wrap with back-to-back ticks
    repeat (600) do_tick(1);
    step();
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_ra_at_wa1", ra_at1, 509);
    // slew down 10 -> 7
    target = 9'd10;
    repeat (8) do_tick(2);
    chk("slew_start", obs_off, 10);
    prev = obs_ra;
    target = 9'd7;
    for (int i = 0; i < 3; i++) begin
      do_tick(2);
      chk("slew_off", obs_off, 9 - i);
      chk("slew_ra_step", wrapd(obs_ra - prev), 2);
      prev = obs_ra;
    end
    // slew up to the largest offset once the buffer is full
    target = 9'd511;
    repeat (510) do_tick(1);
    step();
    chk("slew_sat", obs_off, 511);
    // freeze replay at offset 3 after 20 writes
    do_reset();
    target = 9'd3;
    do_start();
    repeat (20) do_tick(2);
    chk("pre_frz_wa", obs_wa, 19);
    chk("pre_frz_off", obs_off, 3);
    freeze = 1;
    c0 = wr_cnt;
    for (int i = 0; i < 7; i++) begin
      do_tick(2);
      chk("frz_ra", obs_ra, frz_exp[i]);
    end
    chk("frz_writes", wr_cnt - c0, 0);
    chk("frz_state", state, 3);
    freeze = 0;
    do_tick(2);
    chk("unfrz_wa", obs_wa, 20);
    chk("unfrz_ra", obs_ra, 17);
    chk("unfrz_state", state, 2);
    // start and stop together from IDLE
    do_stop();
    chk("stop_state", state, 0);
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("start_stop_state", state, 0);
    // reset right after a RUN tick
    do_start();
    repeat (5) do_tick(2);
    chk("b_run_state", state, 2);
    do_tick(1);
    rst = 1; step(); rst = 0;
    model_reset();
    chk("b_dout_valid", dout_valid, 0);
    chk("b_wr_en", wr_en, 0);
    chk("b_rd_en", rd_en, 0);
    chk("b_wr_addr", wr_addr, 0);
    chk("b_rd_addr", rd_addr, 0);
    chk("b_cur_offset", cur_offset, 1);
    chk("b_state", state, 0);
    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
